// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
//   tx_state_t : transmitter FSM encoding (IDLE, START, DATA, PARITY, STOP)
//   *_LVL      : serial line levels for idle, start and stop bits
//   frame_len  : clocks per frame for a given data width, baud divisor,
//                stop-bit count and parity-bit count
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic START_LVL   = 1'b0;
  localparam logic STOP_LVL    = 1'b1;

  // Total clocks from handshake to the end of the last stop bit.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned clks_per_bit,
                                            input int unsigned stop_bits,
                                            input int unsigned p);
    return clks_per_bit * (1 + data_w + p + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for UART transmit/receive paths.
// Ports:
//   CLK   : clock
//   RESET : synchronous active-high reset
//   clr   : restart the bit period (counter returns to 0 at this edge)
//   tick  : registered, high during the last clock of each bit period
// Parameter CLKS_PER_BIT sets the period; 1 gives a tick every clock.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Counter wraps at the last clock of a period; tick is precomputed from
  // the next count so it is registered yet aligned with that last clock.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits (MSB or LSB
// first), optional parity, STOP_BITS stop bits; each bit lasts CLKS_PER_BIT
// clocks. Valid/ready input handshake, no queueing.
// Ports:
//   CLK     : clock
//   RESET   : synchronous active-high reset
//   data    : word to send, sampled only on valid && ready
//   valid   : producer has a word
//   ready   : idle and able to accept a word (registered)
//   tx      : serial line, idle high (registered)
//   tx_done : one-cycle pulse at the end of the last stop bit (registered)
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD=1).
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              tx_done
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_FIRST =
    (MSB_FIRST != 0) ? IDX_W'(DATA_W - 1) : IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST =
    (MSB_FIRST != 0) ? IDX_W'(0) : IDX_W'(DATA_W - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              tick;
  logic              baud_clr_c;
  logic [IDX_W-1:0]  idx_step_c;
  logic              parity_bit_c;

  // Holding the timer cleared while idle restarts the bit period exactly at
  // the handshake edge; clearing on each tick keeps bit boundaries aligned.
  assign baud_clr_c = (state_q == IDLE) || tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK  (CLK),
    .RESET(RESET),
    .clr  (baud_clr_c),
    .tick (tick)
  );

  // Next data-bit index in transmit order.
  assign idx_step_c = (MSB_FIRST != 0) ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));

  assign parity_bit_c = (^data_q) ^ (PARITY_ODD != 0);

  // Next-state and registered-output logic; tx_d is the level of the bit
  // that starts at the coming edge.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d    = TX_IDLE_LVL;
        ready_d = 1'b1;
        if (valid && ready_q) begin
          state_d    = START;
          data_d     = data;
          idx_d      = IDX_FIRST;
          stop_cnt_d = 1'b0;
          tx_d       = START_LVL;
          ready_d    = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = data_q[IDX_FIRST];
        end
      end

      DATA: begin
        if (tick) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_bit_c;
`else
            state_d = STOP;
            tx_d    = STOP_LVL;
`endif
          end else begin
            idx_d = idx_step_c;
            tx_d  = data_q[idx_step_c];
          end
        end
      end

      // Reachable only when parity is compiled in.
      PARITY: begin
        tx_d = parity_bit_c;
        if (tick) begin
          state_d = STOP;
          tx_d    = STOP_LVL;
        end
      end

      STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = IDLE;
            tx_d    = TX_IDLE_LVL;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = TX_IDLE_LVL;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      data_q     <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= TX_IDLE_LVL;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign ready   = ready_q;
  assign tx      = tx_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: five instances with different
// baud divisor, bit order, stop-bit count and parity sense share stimulus.
// On each predicted handshake the expected per-clock (tx, ready, tx_done)
// waveform is queued; it is popped and compared on every falling edge.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int NDUT = 5;
  localparam int C_A [NDUT] = '{4, 4, 1, 4, 4};
  localparam int S_A [NDUT] = '{1, 1, 1, 2, 2};
  localparam int M_A [NDUT] = '{1, 0, 0, 1, 1};
  localparam int O_A [NDUT] = '{0, 0, 0, 0, 1};
`ifdef UART_TX_PARITY_EN
  localparam int P  = 1;
  localparam int F0 = 44;
`else
  localparam int P  = 0;
  localparam int F0 = 40;
`endif

  typedef struct packed {
    logic tx;
    logic rdy;
    logic done;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [7:0]      data;
  logic [NDUT-1:0] valid;
  logic [NDUT-1:0] ready_w, tx_w, done_w;

  int   total = 0;
  int   bad   = 0;
  logic rst_pend = 1'b1;
  exp_t sb [NDUT][$];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_param #(
      .DATA_W      (8),
      .CLKS_PER_BIT(C_A[g]),
      .STOP_BITS   (S_A[g]),
      .MSB_FIRST   (M_A[g]),
      .PARITY_ODD  (O_A[g])
    ) u_dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .data   (data),
      .valid  (valid[g]),
      .ready  (ready_w[g]),
      .tx     (tx_w[g]),
      .tx_done(done_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Queue the expected waveform of one frame, starting with the clock right
  // after the handshake edge and ending with the tx_done/ready clock.
  task automatic push_frame(input int k, input logic [7:0] w);
    int   f;
    int   b;
    logic lvl;
    f = int'(frame_len(8, C_A[k], S_A[k], P));
    for (int j = 0; j < f; j++) begin
      b = j / C_A[k];
      if (b == 0)                    lvl = 1'b0;
      else if (b <= 8)               lvl = (M_A[k] != 0) ? w[8 - b] : w[b - 1];
      else if (P == 1 && b == 9)     lvl = (^w) ^ (O_A[k] != 0);
      else                           lvl = 1'b1;
      sb[k].push_back('{tx: lvl, rdy: 1'b0, done: 1'b0});
    end
    sb[k].push_back('{tx: 1'b1, rdy: 1'b1, done: 1'b1});
  endtask

  // Scoreboard: compare, then predict a handshake at the coming edge.
  always @(negedge CLK) begin
    for (int k = 0; k < NDUT; k++) begin
      exp_t e;
      if (rst_pend) begin
        sb[k].delete();
        e = '{tx: 1'b1, rdy: 1'b0, done: 1'b0};
      end else if (sb[k].size() > 0) begin
        e = sb[k].pop_front();
      end else begin
        e = '{tx: 1'b1, rdy: 1'b1, done: 1'b0};
      end
      check($sformatf("dut%0d_tx", k),    32'(tx_w[k]),    32'(e.tx));
      check($sformatf("dut%0d_ready", k), 32'(ready_w[k]), 32'(e.rdy));
      check($sformatf("dut%0d_done", k),  32'(done_w[k]),  32'(e.done));
      if (!RESET && valid[k] && e.rdy) push_frame(k, data);
    end
    rst_pend = RESET;
  end

  initial begin
    int cyc;
    RESET = 1'b1;
    valid = '0;
    data  = 8'h00;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Frame 0x0F on all instances; measure the default instance's frame.
    data  = 8'h0F;
    valid = '1;
    @(posedge CLK);
    #1 valid = '0;
    cyc = 0;
    while (!done_w[0] && cyc < 200) begin
      @(posedge CLK);
      #1 cyc++;
    end
    check("dut0_frame_clocks", 32'(cyc), 32'(F0));
    repeat (15) @(posedge CLK);
    #1;

    // Frame 0x07: parity sense on the two-stop-bit instances.
    data  = 8'h07;
    valid = '1;
    @(posedge CLK);
    #1 valid = '0;
    repeat (60) @(posedge CLK);
    #1;

    // valid held high: back-to-back frames, data changes mid-frame ignored.
    data  = 8'h55;
    valid = '1;
    @(posedge CLK);
    #1 data = 8'hAA;
    repeat (60) @(posedge CLK);
    #1 data = 8'h33;
    repeat (60) @(posedge CLK);
    #1 valid = '0;
    repeat (60) @(posedge CLK);
    #1;

    // Reset sampled at clock 13 of a frame.
    data  = 8'hA5;
    valid = '1;
    @(posedge CLK);
    #1 valid = '0;
    repeat (12) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    check("abort_tx", 32'(tx_w[0]), 32'd1);
    check("abort_ready", 32'(ready_w[0]), 32'd0);
    @(posedge CLK);
    #1 check("abort_ready_back", 32'(ready_w[0]), 32'd1);
    check("abort_no_done", 32'(done_w[0]), 32'd0);
    repeat (5) @(posedge CLK);
    #1;

    // Reset and valid on the same edge: nothing accepted.
    RESET = 1'b1;
    valid = '1;
    data  = 8'h00;
    @(posedge CLK);
    #1 RESET = 1'b0;
    valid = '0;
    check("rst_valid_tx", 32'(tx_w), 32'({NDUT{1'b1}}));
    repeat (10) @(posedge CLK);
    #1 check("rst_valid_tx_idle", 32'(tx_w), 32'({NDUT{1'b1}}));
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
